// File: rtl/simd_cs_resolve.sv
// Resolves a 256-bit carry-save SIMD result (ps + (sc<<1), lane-confined) into binary, CHUNK bits per cycle.
// Optional per-lane carry-out port ovf_o is enabled by defining SIMD_CS_RESOLVE_CARRY_OUT_EN.
module simd_cs_resolve #(
  parameter int CHUNK = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [255:0] ps_i,
  input  logic [255:0] sc_i,
  input  logic [2:0]   width_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [255:0] res_o,
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
  output logic [7:0]   ovf_o,
`endif
  output logic [1:0]   state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and payload is held stable while valid is high.

  localparam int N = 256 / CHUNK;
  localparam int S = CHUNK / 32;
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [255:0]   ps_q, sc_q, res_q, sc_sh;
  logic [2:0]     width_q, cnt_q;
  logic           carry_q, carry_d;
  logic           load, step;
  logic [3:0]     lane_sl;
  logic [CHUNK-1:0] chunk_sum;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
  logic [7:0]     ovf_q, ovf_d;
`endif

  // True when 32-bit slice g begins a lane (g == 8 marks the top of the word).
  function automatic logic lane_start(input int g, input logic [3:0] wsl);
    return (4'(g) & (wsl - 4'd1)) == 4'd0;
  endfunction

  always_comb begin
    if (width_q[2])      lane_sl = 4'd8;
    else if (width_q[1]) lane_sl = 4'd4;
    else if (width_q[0]) lane_sl = 4'd2;
    else                 lane_sl = 4'd1;
  end

  // Lane-confined sc shift: the bit entering each lane LSB is forced to zero.
  always_comb begin
    sc_sh = sc_q << 1;
    for (int g = 0; g < 8; g++) begin
      if (lane_start(g, lane_sl)) sc_sh[g*32] = 1'b0;
    end
  end

  always_comb begin
    logic        c;
    logic [31:0] s32;
    int          base, g;
    base      = int'(cnt_q) * CHUNK;
    c         = carry_q;
    s32       = '0;
    chunk_sum = '0;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
    ovf_d     = '0;
`endif
    for (int s = 0; s < S; s++) begin
      g = int'(cnt_q) * S + s;
      if (lane_start(g, lane_sl)) c = 1'b0;
      {c, s32} = {1'b0, ps_q[base+s*32 +: 32]} + {1'b0, sc_sh[base+s*32 +: 32]} + {32'd0, c};
      chunk_sum[s*32 +: 32] = s32;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      if (lane_start(g + 1, lane_sl)) ovf_d[g] = c;
`endif
    end
    carry_d = c;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ps_q    <= '0;
      sc_q    <= '0;
      width_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      ovf_q   <= '0;
`endif
    end else if (load) begin
      ps_q    <= ps_i;
      sc_q    <= sc_i;
      width_q <= width_i;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      ovf_q   <= '0;
`endif
    end else if (step) begin
      res_q[int'(cnt_q)*CHUNK +: CHUNK] <= chunk_sum;
      carry_q <= carry_d;
      cnt_q   <= (cnt_q == LAST) ? 3'd0 : cnt_q + 3'd1;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      ovf_q   <= ovf_q | ovf_d;
`endif
    end
  end

  assign res_o   = res_q;
  assign state_o = state_q;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
  assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_simd_cs_resolve.sv
// Bench for simd_cs_resolve: directed vector table, back-pressure and reset sequences, random ops vs lane model.
module tb_simd_cs_resolve;
  localparam int CHUNK = 64;
  localparam int N = 256 / CHUNK;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [255:0] ps_i = '0, sc_i = '0;
  logic [2:0]   width_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [255:0] res_o;
  logic [1:0]   state_o;
  logic [7:0]   ovf_v;
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
  logic [7:0]   ovf_o;
  assign ovf_v = ovf_o;
`else
  assign ovf_v = 8'h00;
`endif

  simd_cs_resolve #(.CHUNK(CHUNK)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ps_i(ps_i), .sc_i(sc_i), .width_i(width_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .res_o(res_o),
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
    .ovf_o(ovf_o),
`endif
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] exp_q[$];
  logic [7:0]   exp_o_q[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Lane-by-lane reference from the arithmetic definition.
  function automatic void ref_model(input logic [255:0] ps, input logic [255:0] sc, input logic [2:0] w,
                                    output logic [255:0] res, output logic [7:0] ovf);
    int wb;
    logic [256:0] mask, pl, sl, sum;
    wb = w[2] ? 256 : (w[1] ? 128 : (w[0] ? 64 : 32));
    mask = (257'd1 << wb) - 257'd1;
    res = '0;
    ovf = '0;
    for (int l = 0; l < 256 / wb; l++) begin
      pl = ({1'b0, ps} >> (l * wb)) & mask;
      sl = ({1'b0, sc} >> (l * wb)) & mask;
      sum = pl + ((sl << 1) & mask);
      res = res | 256'((sum & mask) << (l * wb));
      ovf[(l * wb + wb - 1) / 32] = sum[wb];
    end
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full transaction with out_ready_i held high; returns result and edges from accept to out_valid.
  task automatic run_op(input logic [255:0] ps, input logic [255:0] sc, input logic [2:0] w,
                        output logic [255:0] r, output logic [7:0] o, output int lat);
    @(negedge clk_i);
    ps_i = ps; sc_i = sc; width_i = w; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    width_i = 3'($urandom_range(0, 7));
    ps_i = rnd256(); sc_i = rnd256();
    chk("ready_in_add", 256'(in_ready_o), 256'(0));
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    r = res_o;
    o = ovf_v;
    @(posedge clk_i); #1;
    chk("idle_after_done", 256'({in_ready_o, out_valid_o}), 256'(2'b10));
  endtask

  typedef struct {
    logic [255:0] ps;
    logic [255:0] sc;
    logic [2:0]   w;
    logic [255:0] er;
    logic [7:0]   eo;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [255:0] r, er, hold;
    logic [7:0]   o, eo;
    int           lat, seen;

    tbl[0] = '{ps: {8{32'hFFFF_FFFF}}, sc: {8{32'h0000_0001}}, w: 3'b000, er: {8{32'h0000_0001}}, eo: 8'hFF};
    tbl[1] = '{ps: {256{1'b1}}, sc: 256'd1, w: 3'b100, er: 256'd1, eo: 8'h80};
    tbl[2] = '{ps: {4{64'h0000_0000_FFFF_FFFF}}, sc: {4{64'd1}}, w: 3'b001,
               er: {4{64'h0000_0001_0000_0001}}, eo: 8'h00};
    tbl[3] = '{ps: 256'd0, sc: {8{32'h8000_0000}}, w: 3'b000, er: 256'd0, eo: 8'h00};
    tbl[4] = '{ps: 256'd0, sc: 256'd1 << 127, w: 3'b110, er: 256'd1 << 128, eo: 8'h00};
    tbl[5] = '{ps: 256'd0, sc: (256'd1 << 127) | (256'd1 << 63), w: 3'b011, er: 256'd1 << 64, eo: 8'h00};

    // Reset state
    #12;
    chk("rst_ready", 256'(in_ready_o), 256'(1));
    chk("rst_valid", 256'(out_valid_o), 256'(0));
    chk("rst_res", res_o, 256'd0);
    chk("rst_ovf", 256'(ovf_v), 256'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].ps, tbl[i].sc, tbl[i].w, r, o, lat);
      chk($sformatf("vec%0d_lat", i), 256'(lat), 256'(N));
      chk($sformatf("vec%0d_res", i), r, tbl[i].er);
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      chk($sformatf("vec%0d_ovf", i), 256'(o), 256'(tbl[i].eo));
`endif
    end

    // Back-pressure in DONE with in_valid_i held high, then a follow-on accept.
    @(negedge clk_i);
    ps_i = tbl[0].ps; sc_i = tbl[0].sc; width_i = 3'b000; in_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    ps_i = {8{32'h0000_0010}}; sc_i = {8{32'h0000_0003}}; width_i = 3'b001;
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("bp_lat", 256'(lat), 256'(N));
    hold = res_o;
    chk("bp_res", hold, tbl[0].er);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk("bp_stable", res_o, hold);
      chk("bp_flags", 256'({out_valid_o, in_ready_o}), 256'(2'b10));
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_exit_idle", 256'({out_valid_o, in_ready_o}), 256'(2'b01));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("bp_next_accept", 256'(in_ready_o), 256'(0));
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    ref_model({8{32'h0000_0010}}, {8{32'h0000_0003}}, 3'b001, er, eo);
    chk("bp_next_lat", 256'(lat), 256'(N));
    chk("bp_next_res", res_o, er);
    @(posedge clk_i); #1;

    // Reset pulse while chunk 1 is in progress.
    @(negedge clk_i);
    ps_i = tbl[1].ps; sc_i = tbl[1].sc; width_i = 3'b100; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #3;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", 256'(in_ready_o), 256'(1));
    chk("mid_rst_res", res_o, 256'd0);
    #2;
    rst_n_i = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen++;
    end
    chk("mid_rst_no_result", 256'(seen), 256'(0));
    chk("mid_rst_ready_after", 256'(in_ready_o), 256'(1));

    // Random operands against the lane model.
    for (int i = 0; i < 24; i++) begin
      logic [255:0] ps, sc;
      logic [2:0]   w;
      ps = rnd256();
      sc = rnd256();
      if ($urandom_range(0, 2) == 0) ps = ~sc;
      w = 3'($urandom_range(0, 7));
      ref_model(ps, sc, w, er, eo);
      exp_q.push_back(er);
      exp_o_q.push_back(eo);
      run_op(ps, sc, w, r, o, lat);
      chk($sformatf("rnd%0d_lat", i), 256'(lat), 256'(N));
      chk($sformatf("rnd%0d_res", i), r, exp_q.pop_front());
      eo = exp_o_q.pop_front();
`ifdef SIMD_CS_RESOLVE_CARRY_OUT_EN
      chk($sformatf("rnd%0d_ovf", i), 256'(o), 256'(eo));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
